// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: scanout reads take strict priority, writer pixels
// are buffered one deep and issued in free cycles (optionally vblank only).
module vga_fb_arbiter #(
  parameter int AW             = 19,
  parameter int DW             = 12,
  parameter int WR_VBLANK_ONLY = 0,
  parameter int STARVE_MAX     = 1023
) (
  input  logic          clk,
  input  logic          i_sclr,
  input  logic          i_px_clk,
  input  logic          i_vaddr_en,
  input  logic          i_disp_req,
  input  logic [AW-1:0] i_disp_addr,
  output logic [DW-1:0] o_disp_rdata,
  output logic          o_disp_rvalid,
  input  logic          i_wr_valid,
  output logic          o_wr_ready,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  output logic          o_ram_en,
  output logic          o_ram_we,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_wdata,
  input  logic [DW-1:0] i_ram_rdata,
  output logic          o_wr_starve
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, DISP, WR} gnt_t;

  gnt_t          gnt;
  logic          rd_stage;
  logic          pend_valid;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_data;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_nxt;

  logic disp_hit;
  logic vblank_ok;
  logic wr_ok;
  logic wr_accept;

  assign disp_hit   = i_disp_req & i_px_clk;
  assign vblank_ok  = (WR_VBLANK_ONLY == 0) || !i_vaddr_en;
  assign wr_ok      = pend_valid & ~disp_hit & vblank_ok;
  // Combinational so the buffer can refill in the same cycle it drains.
  assign o_wr_ready = ~pend_valid | wr_ok;
  assign wr_accept  = i_wr_valid & o_wr_ready;

  always_comb begin
    starve_nxt = starve_cnt;
    if (!pend_valid || wr_ok)
      starve_nxt = '0;
    else if (starve_cnt != CW'(STARVE_MAX))
      starve_nxt = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      gnt           <= IDLE;
      rd_stage      <= 1'b0;
      pend_valid    <= 1'b0;
      pend_addr     <= '0;
      pend_data     <= '0;
      starve_cnt    <= '0;
      o_wr_starve   <= 1'b0;
      o_ram_en      <= 1'b0;
      o_ram_we      <= 1'b0;
      o_ram_addr    <= '0;
      o_ram_wdata   <= '0;
      o_disp_rdata  <= '0;
      o_disp_rvalid <= 1'b0;
    end else begin
      if (disp_hit)   gnt <= DISP;
      else if (wr_ok) gnt <= WR;
      else            gnt <= IDLE;

      o_ram_en <= disp_hit | wr_ok;
      o_ram_we <= wr_ok;
      if (disp_hit) begin
        o_ram_addr <= i_disp_addr;
      end else if (wr_ok) begin
        o_ram_addr  <= pend_addr;
        o_ram_wdata <= pend_data;
      end

      if (wr_accept) begin
        pend_addr <= i_wr_addr;
        pend_data <= i_wr_data;
      end
      pend_valid <= wr_accept | (pend_valid & ~wr_ok);

      // gnt is the first read-tracking stage; rd_stage marks RAM data arriving.
      rd_stage      <= (gnt == DISP);
      o_disp_rvalid <= rd_stage;
      if (rd_stage) o_disp_rdata <= i_ram_rdata;

      starve_cnt  <= starve_nxt;
      o_wr_starve <= (starve_nxt == CW'(STARVE_MAX));
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: a transaction-level model predicts RAM
// accesses, read returns and starvation; a monitor compares at negedge.
module tb_vga_fb_arbiter;
  logic        clk = 1'b0;
  logic        sclr = 1'b1, px_clk = 1'b0, vaddr_en = 1'b0, disp_req = 1'b0;
  logic [18:0] disp_addr = '0, wr_addr = '0;
  logic [11:0] wr_data = '0, disp_rdata, ram_wdata, ram_rdata;
  logic        disp_rvalid, wr_valid = 1'b0, wr_ready;
  logic        ram_en, ram_we, wr_starve;
  logic [18:0] ram_addr;

  vga_fb_arbiter #(.AW(19), .DW(12), .WR_VBLANK_ONLY(1), .STARVE_MAX(1023)) dut (
    .clk(clk), .i_sclr(sclr), .i_px_clk(px_clk), .i_vaddr_en(vaddr_en),
    .i_disp_req(disp_req), .i_disp_addr(disp_addr), .o_disp_rdata(disp_rdata),
    .o_disp_rvalid(disp_rvalid), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_ram_en(ram_en), .o_ram_we(ram_we),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
    .o_wr_starve(wr_starve));

  always #5 clk = ~clk;

  logic [11:0] ram [0:524287];
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {int due; bit we; int addr; int data;} ev_t;
  ev_t ram_q[$], rd_q[$], st_q[$];

  // Reference state: framebuffer contents as seen in grant order, write buffer, wait count.
  logic [11:0] m_mem [0:127];
  bit          m_pend = 0;
  int          m_addr = 0, m_data = 0, m_cnt = 0;
  bit          mon_on = 0;

  task automatic step(input bit rst, input bit px, input bit vae, input bit dreq,
                      input int daddr, input bit wv, input int waddr, input int wdata,
                      output bit acc);
    bit hit, ok, rdy;
    @(posedge clk); #1;
    sclr = rst; px_clk = px; vaddr_en = vae; disp_req = dreq;
    disp_addr = 19'(daddr); wr_valid = wv; wr_addr = 19'(waddr); wr_data = 12'(wdata);
    #1;
    acc = 0;
    if (rst) begin
      while (ram_q.size() > 0 && ram_q[$].due > cyc) void'(ram_q.pop_back());
      while (rd_q.size() > 0 && rd_q[$].due > cyc) void'(rd_q.pop_back());
      while (st_q.size() > 0 && st_q[$].due > cyc) void'(st_q.pop_back());
      m_pend = 0; m_cnt = 0;
      st_q.push_back('{cyc + 1, 0, 0, 0});
    end else begin
      hit = dreq && px;
      ok  = m_pend && !hit && !vae;
      rdy = !m_pend || ok;
      chk("wr_ready", 32'(wr_ready), 32'(rdy));
      acc = wv && rdy;
      if (hit) begin
        ram_q.push_back('{cyc + 1, 0, daddr, 0});
        rd_q.push_back('{cyc + 3, 0, daddr, int'(m_mem[daddr])});
      end else if (ok) begin
        ram_q.push_back('{cyc + 1, 1, m_addr, m_data});
        m_mem[m_addr] = 12'(m_data);
      end
      if (!m_pend || ok) m_cnt = 0;
      else if (m_cnt < 1023) m_cnt++;
      st_q.push_back('{cyc + 1, 0, 0, int'(m_cnt == 1023)});
      if (acc) begin m_addr = waddr; m_data = wdata; end
      m_pend = acc || (m_pend && !ok);
    end
  endtask

  task automatic idle(input int n, input bit vae);
    bit a;
    for (int i = 0; i < n; i++) step(0, 0, vae, 0, 0, 0, 0, 0, a);
  endtask

  always @(negedge clk) if (mon_on) begin
    ev_t e;
    if (ram_q.size() > 0 && ram_q[0].due == cyc) begin
      e = ram_q.pop_front();
      chk("ram_en", 32'(ram_en), 1);
      chk("ram_we", 32'(ram_we), 32'(e.we));
      chk("ram_addr", 32'(ram_addr), 32'(e.addr));
      if (e.we) chk("ram_wdata", 32'(ram_wdata), 32'(e.data));
    end else begin
      chk("ram_idle_en", 32'(ram_en), 0);
    end
    if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
      e = rd_q.pop_front();
      chk("rvalid", 32'(disp_rvalid), 1);
      chk("rdata", 32'(disp_rdata), 32'(e.data));
    end else begin
      chk("rvalid_idle", 32'(disp_rvalid), 0);
    end
    while (st_q.size() > 0 && st_q[0].due < cyc) void'(st_q.pop_front());
    if (st_q.size() > 0 && st_q[0].due == cyc) begin
      e = st_q.pop_front();
      chk("wr_starve", 32'(wr_starve), 32'(e.data));
    end
  end

  initial begin
    bit a;
    int n_acc, k;
    for (int i = 0; i < 128; i++) begin ram[i] = 12'h0; m_mem[i] = 12'h0; end
    ram[100] = 12'hABC; m_mem[100] = 12'hABC;

    step(1, 0, 0, 0, 0, 0, 0, 0, a);
    step(1, 0, 0, 0, 0, 0, 0, 0, a);
    mon_on = 1;
    idle(1, 0);
    chk("reset_ram_addr", 32'(ram_addr), 0);
    chk("reset_rdata", 32'(disp_rdata), 0);
    chk("reset_ready", 32'(wr_ready), 1);

    // read latency, plus disp_req without px_clk ignored
    step(0, 1, 1, 1, 100, 0, 0, 0, a);
    step(0, 0, 1, 1, 101, 0, 0, 0, a);
    idle(4, 0);

    // collision: pending write vs display hit
    step(0, 0, 0, 0, 0, 1, 5, 12'h123, a);
    chk("coll_acc0", 32'(a), 1);
    step(0, 1, 0, 1, 9, 1, 6, 12'h456, a);
    chk("coll_blocked", 32'(a), 0);
    step(0, 0, 0, 0, 0, 1, 6, 12'h456, a);
    chk("coll_refill", 32'(a), 1);
    idle(4, 0);

    // streaming 8 pixels, px_clk every 4th cycle
    n_acc = 0;
    for (int i = 0; i < 100 && n_acc < 8; i++) begin
      step(0, (i % 4) == 0, 0, 1, 40, 1, 32 + n_acc, 12'h500 + n_acc, a);
      if (a) n_acc++;
    end
    chk("stream_count", 32'(n_acc), 8);
    idle(4, 0);
    step(0, 1, 1, 1, 35, 0, 0, 0, a);
    idle(4, 0);

    // write then read same address
    step(0, 0, 0, 0, 0, 1, 7, 12'hF00, a);
    step(0, 0, 0, 0, 0, 0, 0, 0, a);
    step(0, 1, 0, 1, 7, 0, 0, 0, a);
    idle(4, 0);

    // vblank gating and starvation
    step(0, 0, 1, 0, 0, 1, 11, 12'h0A5, a);
    chk("vb_acc", 32'(a), 1);
    for (int i = 0; i < 2000; i++) step(0, (i % 3) == 0, 1, 1, 11, 0, 0, 0, a);
    chk("starve_set", 32'(wr_starve), 1);
    idle(4, 0);
    chk("starve_clear", 32'(wr_starve), 0);

    // reset one cycle after display hit with a write pending
    step(0, 0, 1, 0, 0, 1, 12, 12'h777, a);
    step(0, 1, 1, 1, 12, 0, 0, 0, a);
    step(1, 0, 1, 0, 0, 0, 0, 0, a);
    idle(1, 0);
    chk("mr_en", 32'(ram_en), 0);
    chk("mr_we", 32'(ram_we), 0);
    chk("mr_addr", 32'(ram_addr), 0);
    chk("mr_wdata", 32'(ram_wdata), 0);
    chk("mr_rvalid", 32'(disp_rvalid), 0);
    chk("mr_rdata", 32'(disp_rdata), 0);
    chk("mr_starve", 32'(wr_starve), 0);
    chk("mr_ready", 32'(wr_ready), 1);
    idle(4, 0);

    // randomized traffic
    begin
      bit vae = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 15) == 0) vae = !vae;
        k = $urandom_range(0, 15);
        step($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, vae,
             $urandom_range(0, 3) != 0, k, $urandom_range(0, 1) == 1,
             $urandom_range(0, 15), $urandom_range(0, 4095), a);
      end
    end
    idle(8, 0);
    chk("ram_q_drained", 32'(ram_q.size()), 0);
    chk("rd_q_drained", 32'(rd_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
